// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and coordinate type for the raster generator.
package vga_pkg;
   localparam int COORD_W      = 10;
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active-low sync.
// 'active' reports the region of the count about to be loaded, so the parent can register it.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL      = 800,
   parameter int SYNC_START = 656,
   parameter int SYNC_LEN   = 96,
   parameter int ACTIVE     = 640
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en,
   output coord_t count,
   output logic   sync_n,
   output logic   active,
   output logic   wrap
);
   localparam coord_t LAST      = coord_t'(TOTAL - 1);
   localparam int     SYNC_END  = SYNC_START + SYNC_LEN;
   localparam logic   SYNC_N_RST = !(SYNC_START == 0 && SYNC_LEN > 0);

   coord_t count_q, count_d;
   logic   sync_n_q, sync_n_d;

   always_comb begin
      wrap    = en && (count_q == LAST);
      count_d = count_q;
      if (en) count_d = wrap ? '0 : count_q + 1'b1;
      // Decode from the next count so sync lands on the same edge as the position.
      sync_n_d = !((int'(count_d) >= SYNC_START) && (int'(count_d) < SYNC_END));
      active   = int'(count_d) < ACTIVE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         sync_n_q <= SYNC_N_RST;
      end else begin
         count_q  <= count_d;
         sync_n_q <= sync_n_d;
      end
   end

   assign count  = count_q;
   assign sync_n = sync_n_q;
endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: DrawX/DrawY, hs/vs, blank and frame_done, all flop outputs.
// Optional VGA_FRAME_CNT_EN adds an 8-bit frame counter port.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output coord_t     DrawX,
   output coord_t     DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_done
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0] frame_cnt
`endif
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam coord_t V_LAST_ACTIVE = coord_t'(V_ACTIVE - 1);

   if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_timing
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
   end

   coord_t h_count, v_count;
   logic   h_sync_n, v_sync_n, h_active, v_active, h_wrap, v_wrap;
   logic   blank_q, blank_d, frame_done_q, frame_done_d;

   vga_axis_counter #(
      .TOTAL(H_TOTAL), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC), .ACTIVE(H_ACTIVE)
   ) u_h (
      .clk(vga_clk), .rst_n(reset_n), .en(1'b1),
      .count(h_count), .sync_n(h_sync_n), .active(h_active), .wrap(h_wrap)
   );

   vga_axis_counter #(
      .TOTAL(V_TOTAL), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC), .ACTIVE(V_ACTIVE)
   ) u_v (
      .clk(vga_clk), .rst_n(reset_n), .en(h_wrap),
      .count(v_count), .sync_n(v_sync_n), .active(v_active), .wrap(v_wrap)
   );

   always_comb begin
      blank_d      = h_active && v_active;
      // Next position is (0, V_ACTIVE) when the last active line wraps horizontally.
      frame_done_d = h_wrap && (v_count == V_LAST_ACTIVE);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         blank_q      <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         blank_q      <= blank_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      if (frame_done_d) frame_cnt_d = frame_cnt_q + 8'd1;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) frame_cnt_q <= '0;
      else          frame_cnt_q <= frame_cnt_d;
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign DrawX      = h_count;
   assign DrawY      = v_count;
   assign hs         = h_sync_n;
   assign vs         = v_sync_n;
   assign blank      = blank_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for reset/horizontal timing, small-raster instance
// (8x8 totals, 64-cycle frame) for vertical timing, frame_done and mid-frame reset.
module tb_vga_timing_gen;
   logic       vga_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [9:0] dx, dy, sx, sy;
   logic       hs, vs, blank, fd;
   logic       hs_s, vs_s, blank_s, fd_s;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] fc, fc_s;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #20 vga_clk = ~vga_clk;

   vga_timing_gen dut (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(dx), .DrawY(dy),
      .hs(hs), .vs(vs), .blank(blank), .frame_done(fd)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(fc)
`endif
   );

   // Small raster: H 4/1/2/1 (total 8, hs low hc 5..6), V 4/1/1/2 (total 8, vs low vc 5).
   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2)
   ) dut_s (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(sx), .DrawY(sy),
      .hs(hs_s), .vs(vs_s), .blank(blank_s), .frame_done(fd_s)
`ifdef VGA_FRAME_CNT_EN
      , .frame_cnt(fc_s)
`endif
   );

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string ph);
      chk({ph, " DrawX"}, dx, 0);  chk({ph, " DrawY"}, dy, 0);
      chk({ph, " hs"}, hs, 1);     chk({ph, " vs"}, vs, 1);
      chk({ph, " blank"}, blank, 1); chk({ph, " frame_done"}, fd, 0);
      chk({ph, " s DrawX"}, sx, 0); chk({ph, " s DrawY"}, sy, 0);
      chk({ph, " s hs"}, hs_s, 1);  chk({ph, " s vs"}, vs_s, 1);
      chk({ph, " s blank"}, blank_s, 1); chk({ph, " s frame_done"}, fd_s, 0);
`ifdef VGA_FRAME_CNT_EN
      chk({ph, " frame_cnt"}, fc, 0); chk({ph, " s frame_cnt"}, fc_s, 0);
`endif
   endtask

   initial begin
      int hs_low, hs_first, hs_last, blank_fall, vs_low, vs_s_low, hs_s_low, fd_cnt;
      int fd_s_cnt, fd_s_first, fd_s_second, fd_s_last;
      hs_low = 0; hs_first = -1; hs_last = -1; blank_fall = -1; vs_low = 0;
      vs_s_low = 0; hs_s_low = 0; fd_cnt = 0; fd_s_cnt = 0;
      fd_s_first = -1; fd_s_second = -1; fd_s_last = -1;

      // Reset held across several edges.
      repeat (3) @(negedge vga_clk);
      chk_reset_vals("rst");
      reset_n = 1'b1;   // released at a negedge; next posedge is cycle 1

      for (int cyc = 1; cyc <= 1700; cyc++) begin
         @(negedge vga_clk);
         if (cyc == 1) begin
            chk("c1 DrawX", dx, 1); chk("c1 DrawY", dy, 0); chk("c1 blank", blank, 1);
         end
         if (cyc < 800) begin
            if (!hs) begin
               hs_low++;
               if (hs_first < 0) hs_first = cyc;
               hs_last = cyc;
            end
            if (!blank && blank_fall < 0) blank_fall = cyc;
         end
         if (cyc == 799) begin chk("c799 DrawX", dx, 799); chk("c799 DrawY", dy, 0); end
         if (cyc == 800) begin
            chk("c800 DrawX", dx, 0); chk("c800 DrawY", dy, 1); chk("c800 blank", blank, 1);
         end
         if (cyc == 1600) chk("c1600 DrawY", dy, 2);
         if (!vs) vs_low++;
         if (fd) fd_cnt++;
         // Small raster
         if (cyc < 8 && !hs_s) hs_s_low++;
         if (cyc == 5) chk("s c5 hs", hs_s, 0);
         if (cyc < 64 && !vs_s) vs_s_low++;
         if (cyc == 40) chk("s c40 vs", vs_s, 0);
         if (cyc == 48) chk("s c48 vs", vs_s, 1);
         if (cyc == 63) begin chk("s c63 DrawX", sx, 7); chk("s c63 DrawY", sy, 7); end
         if (cyc == 64) begin chk("s c64 DrawX", sx, 0); chk("s c64 DrawY", sy, 0); end
         if (fd_s) begin
            fd_s_cnt++;
            if (fd_s_cnt == 1) begin
               fd_s_first = cyc;
               chk("s fd DrawX", sx, 0); chk("s fd DrawY", sy, 4); chk("s fd blank", blank_s, 0);
`ifdef VGA_FRAME_CNT_EN
               chk("s fd1 frame_cnt", fc_s, 1);
`endif
            end
            if (fd_s_cnt == 2) fd_s_second = cyc;
         end
      end
      chk("hs low count", hs_low, 96);
      chk("hs first low", hs_first, 656);
      chk("hs last low", hs_last, 751);
      chk("blank fall", blank_fall, 640);
      chk("vs low lines 0-2", vs_low, 0);
      chk("no early frame_done", fd_cnt, 0);
      chk("s hs low count", hs_s_low, 2);
      chk("s vs low count", vs_s_low, 8);
      chk("s fd first", fd_s_first, 32);
      chk("s fd second", fd_s_second, 96);
      // Full DUT now at (100,2); small DUT at (4,4).
      chk("pre-rst DrawX", dx, 100);
      chk("pre-rst s DrawY", sy, 4);

      // Mid-frame reset between clock edges, checked before any edge occurs.
      #5 reset_n = 1'b0;
      #1 chk_reset_vals("async rst");
      @(negedge vga_clk);
      reset_n = 1'b1;

      fd_s_cnt = 0; fd_s_first = -1; fd_s_last = -1; fd_cnt = 0;
      for (int cyc = 1; cyc <= 16352; cyc++) begin
         @(negedge vga_clk);
         if (fd) fd_cnt++;
         if (fd_s) begin
            fd_s_cnt++;
            if (fd_s_first < 0) fd_s_first = cyc;
            fd_s_last = cyc;
`ifdef VGA_FRAME_CNT_EN
            if (fd_s_cnt == 1)   chk("rel fd1 frame_cnt", fc_s, 1);
            if (fd_s_cnt == 256) chk("fd256 frame_cnt wrap", fc_s, 0);
`endif
         end
      end
      chk("post-rst s fd first", fd_s_first, 32);
      chk("s fd count 256 frames", fd_s_cnt, 256);
      chk("s fd last", fd_s_last, 16352);
      chk("post-rst no full fd", fd_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from the 25 MHz pixel clock. It produces the DrawX/DrawY/blank interface that the sprite ROM readers and palette blocks consume, plus active-low hsync/vsync for the monitor. A one-cycle frame_done strobe marks the start of vertical blanking, so sprite and animation state can be updated safely between frames.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
vga_clk  input  1  pixel clock, 25 MHz
reset_n  input  1  asynchronous, active-low reset
DrawX  output  10  current pixel column, 0..H_TOTAL-1
DrawY  output  10  current line, 0..V_TOTAL-1
hs  output  1  horizontal sync, active low
vs  output  1  vertical sync, active low
blank  output  1  1 = visible region (pixel may be driven); 0 = blanking
frame_done  output  1  one-cycle pulse at the first pixel of vertical blanking
frame_cnt  output  8  frame counter; present only with VGA_FRAME_CNT_EN

Behaviour:
- Clock and reset: one clock, vga_clk. Reset is asynchronous and active-low on reset_n.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Outputs: all are flop outputs and all describe the same raster position (hc,vc) in the same cycle. No combinational decode is allowed on the output path.
- hc increments every cycle and wraps from H_TOTAL-1 to 0.
- vc increments only when hc wraps, and itself wraps from V_TOTAL-1 to 0.
- DrawX = hc and DrawY = vc.
- hs = 0 iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. hc 656..751.
- vs = 0 iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. vc 490..491.
- blank = 1 iff hc < H_ACTIVE and vc < V_ACTIVE.
- frame_done = 1 iff (hc,vc) = (0,V_ACTIVE); it is high for exactly 1 cycle per frame.
- Reset values: position (0,0), so DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_done=0 (and frame_cnt=0).
- Reset release: the first rising edge after release advances to (1,0). Line 0 is a full line.
- Reset asserted mid-frame: all outputs return to the reset values immediately (asynchronous). No partial frame_done is produced.
- Arithmetic: comparisons are unsigned at 10 bits. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; violations are caught by an elaboration-time assertion.
- Period: line = 800 cycles; frame = 420000 cycles.

Optional Feature:
Macro VGA_FRAME_CNT_EN.
- Defined: the frame_cnt port exists. frame_cnt is an 8-bit register, reset to 0. It increments on the same edge at which frame_done rises, so it reads N+1 during the frame_done cycle. It wraps 255 -> 0. Sprite blocks use it to select animation frames.
- Undefined: neither the port nor the register exists, and all other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants (H_/V_ values);
  - COORD_W = 10;
  - the typedef coord_t = logic [COORD_W-1:0].
- Sub-module vga_axis_counter (parameters TOTAL, SYNC_START, SYNC_LEN, ACTIVE) is instantiated twice:
  - horizontal: always enabled;
  - vertical: enable = horizontal wrap.
- Each instance outputs count, sync_n, active and wrap. The top level combines them into blank and frame_done.

Test Plan:
- Reset held, then released -> during reset DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_done=0. Cycle 1 after release: DrawX=1.
- Horizontal timing -> blank falls at DrawX=640. hs is low exactly for DrawX 656..751 (96 cycles). DrawX goes 799 -> 0 with DrawY 0 -> 1.
- Vertical timing -> vs is low only on lines 490 and 491 (1600 cycles). DrawY wraps 524 -> 0 at cycle 420000 after release.
- frame_done -> single-cycle pulse at cycle 384000 after release with (DrawX,DrawY)=(0,480), then every 420000 cycles. blank=0 in that cycle.
- Reset mid-frame at (300,200) -> all outputs go to reset values without waiting for a clock edge. frame_done does not fire until 384000 cycles after the new release.
- With VGA_FRAME_CNT_EN -> frame_cnt=1 during the first frame_done cycle and 0 after 256 frames. Rebuild without the macro and confirm the port is absent and all other outputs match cycle-for-cycle.
